// File: rtl/dmem_pkg.sv
// Shared types for the data-memory write-buffer front end.
//   WB_AW / WB_DW  : default address / data widths used by dmem_wbuf
//   dmem_state_t   : handshake FSM states
//   wbuf_entry_t   : one buffered store (word address + data) at the default widths
package dmem_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_BUSY = 2'd1,
        RD_BUSY = 2'd2,
        RD_DONE = 2'd3
    } dmem_state_t;

    typedef struct packed {
        logic [WB_AW-3:0] waddr;
        logic [WB_DW-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Circular store buffer for dmem_wbuf.
//   clk, reset (sync, active-low)
//   push / push_waddr / push_data : enqueue at the tail (caller guarantees !full)
//   pop                           : drop the head (caller guarantees !empty)
//   lookup_waddr -> hit/hit_data  : youngest valid entry matching the word address
//   head_*                        : oldest entry
//   second_*                      : entry that becomes head after a pop this cycle
//                                   (the pushed entry when only one is stored)
//   count / full / empty          : occupancy, 0..DEPTH
module wbuf_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [AW-3:0] push_waddr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic [AW-3:0] lookup_waddr,
    output logic          hit,
    output logic [DW-1:0] hit_data,
    output logic [AW-3:0] head_waddr,
    output logic [DW-1:0] head_data,
    output logic [AW-3:0] second_waddr,
    output logic [DW-1:0] second_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    // Every entry is compared on each lookup, so storage lives in flops.
    logic [AW-3:0] waddr_mem [DEPTH];
    logic [DW-1:0] data_mem  [DEPTH];

    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [PW-1:0] rd_ptr_inc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Contents need no reset: count=0 marks every slot invalid.
    always_ff @(posedge clk) begin
        if (push) begin
            waddr_mem[wr_ptr_reg] <= push_waddr;
            data_mem[wr_ptr_reg]  <= push_data;
        end
    end

    // Age-ordered view: age 0 is the head, age count-1 the youngest entry.
    logic [DEPTH-1:0] age_match;
    logic [DW-1:0]    age_data [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PW-1:0] slot;
            assign slot          = rd_ptr_reg + PW'(gi);
            assign age_match[gi] = (CW'(gi) < count_reg) && (waddr_mem[slot] == lookup_waddr);
            assign age_data[gi]  = data_mem[slot];
        end
    endgenerate

    // Later (younger) matches override earlier ones.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (age_match[i]) begin
                hit      = 1'b1;
                hit_data = age_data[i];
            end
        end
    end

    assign rd_ptr_inc = rd_ptr_reg + PW'(1);

    assign head_waddr   = waddr_mem[rd_ptr_reg];
    assign head_data    = data_mem[rd_ptr_reg];
    // With a single stored entry the next head can only be the one being pushed now.
    assign second_waddr = (count_reg > CW'(1)) ? waddr_mem[rd_ptr_inc] : push_waddr;
    assign second_data  = (count_reg > CW'(1)) ? data_mem[rd_ptr_inc]  : push_data;

    assign count = count_reg;
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

    a_count_range: assert property (@(posedge clk) disable iff (!reset)
        count_reg <= CW'(DEPTH));
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        push |-> !(full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        pop |-> !empty);

endmodule

// File: rtl/dmem_wbuf.sv
// Data-memory front end with a posted-store write buffer.
//   clk, reset (sync, active-low)
//   CPU side : memwrite, memread, addr, writedata -> readdata, stall
//   Memory   : mem_req, mem_we, mem_addr, mem_wdata (registered) <- mem_ack, mem_rdata
// Stores post into wbuf_fifo and drain in program order; loads forward from the
// youngest matching buffered store, otherwise stall and read through the FSM.
module dmem_wbuf
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwrite,
    input  logic          memread,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] writedata,
    output logic [DW-1:0] readdata,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(DEPTH + 1);

    dmem_state_t   state_reg, state_next;
    logic          mem_req_reg, mem_req_next;
    logic          mem_we_reg, mem_we_next;
    logic [AW-1:0] mem_addr_reg, mem_addr_next;
    logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
    logic [DW-1:0] hold_reg, hold_next;

    logic [AW-3:0] cur_waddr;
    logic          addr_lsb_unused;
    logic          is_store, is_load, in_rd_done;
    logic          push, pop, load_miss, more_after_pop;

    logic          hit, full, empty;
    logic [DW-1:0] hit_data, head_data, second_data;
    logic [AW-3:0] head_waddr, second_waddr;
    logic [CW-1:0] count;

    assign cur_waddr       = addr[AW-1:2];
    assign addr_lsb_unused = &{1'b0, addr[1:0]};

    // A simultaneous read+write is a store.
    assign is_store   = memwrite;
    assign is_load    = memread & ~memwrite;
    assign in_rd_done = (state_reg == RD_DONE);

    // Full is judged on the registered count: a pop this cycle does not free a slot yet.
    assign push      = is_store & ~full;
    // In RD_DONE the held load retires from the hold register.
    assign load_miss = is_load & ~hit & ~in_rd_done;
    assign stall     = (is_store & full) | load_miss;

    // Occupancy after popping the head stays non-zero if more remain or one arrives.
    assign more_after_pop = (count > CW'(1)) | push;

    wbuf_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .push_waddr   (cur_waddr),
        .push_data    (writedata),
        .pop          (pop),
        .lookup_waddr (cur_waddr),
        .hit          (hit),
        .hit_data     (hit_data),
        .head_waddr   (head_waddr),
        .head_data    (head_data),
        .second_waddr (second_waddr),
        .second_data  (second_data),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    always_comb begin
        readdata = '0;
        if (is_load) begin
            if (in_rd_done) readdata = hold_reg;
            else if (hit)   readdata = hit_data;
        end
    end

    // Next-state and next registered memory-side outputs.
    always_comb begin
        state_next     = state_reg;
        mem_req_next   = mem_req_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        hold_next      = hold_reg;
        pop            = 1'b0;

        case (state_reg)
            IDLE: begin
                if (load_miss) begin
                    state_next    = RD_BUSY;
                    mem_req_next  = 1'b1;
                    mem_we_next   = 1'b0;
                    mem_addr_next = {cur_waddr, 2'b00};
                end else if (!empty) begin
                    state_next     = WR_BUSY;
                    mem_req_next   = 1'b1;
                    mem_we_next    = 1'b1;
                    mem_addr_next  = {head_waddr, 2'b00};
                    mem_wdata_next = head_data;
                end else begin
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                end
            end

            WR_BUSY: begin
                if (mem_ack) begin
                    pop = 1'b1;
                    if (load_miss) begin
                        state_next    = RD_BUSY;
                        mem_req_next  = 1'b1;
                        mem_we_next   = 1'b0;
                        mem_addr_next = {cur_waddr, 2'b00};
                    end else if (more_after_pop) begin
                        state_next     = WR_BUSY;
                        mem_req_next   = 1'b1;
                        mem_we_next    = 1'b1;
                        mem_addr_next  = {second_waddr, 2'b00};
                        mem_wdata_next = second_data;
                    end else begin
                        state_next   = IDLE;
                        mem_req_next = 1'b0;
                        mem_we_next  = 1'b0;
                    end
                end
            end

            RD_BUSY: begin
                if (mem_ack) begin
                    hold_next    = mem_rdata;
                    state_next   = RD_DONE;
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                end
            end

            RD_DONE: begin
                state_next   = IDLE;
                mem_req_next = 1'b0;
                mem_we_next  = 1'b0;
            end

            default: begin
                state_next   = IDLE;
                mem_req_next = 1'b0;
                mem_we_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            hold_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            hold_reg      <= hold_next;
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

    a_req_stable: assert property (@(posedge clk) disable iff (!reset)
        (mem_req && !mem_ack) |=> ($stable(mem_addr) && $stable(mem_we) && $stable(mem_wdata)));

endmodule

// File: tb/tb_dmem_wbuf.sv
module tb_dmem_wbuf;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic        memread = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata = '0;

    logic        resp_ack = 1'b0;
    logic        manual_ack = 1'b0;
    assign mem_ack = resp_ack | manual_ack;

    always #5 clk = ~clk;

    dmem_wbuf #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .memread   (memread),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        bit          we;
        logic [31:0] a;
        logic [31:0] d;
    } bus_t;

    bus_t        bus_q[$];
    logic [31:0] load_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    int          ack_delay = 1;
    bit          ack_hold = 1'b1;
    int          wait_cnt = 0;
    logic [31:0] rdata_val = '0;

    // Memory model: ack ack_delay cycles after the request is seen.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            resp_ack = 1'b0;
            if (reset && mem_req && !ack_hold) begin
                wait_cnt++;
                if (wait_cnt >= ack_delay) begin
                    resp_ack  = 1'b1;
                    mem_rdata = rdata_val;
                    wait_cnt  = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: compare each completed bus transfer and each retired load.
    bus_t        mon_e;
    logic [31:0] mon_ld;
    always @(negedge clk) begin
        if (reset) begin
            if (mem_req && mem_ack) begin
                vectors++;
                if (bus_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL bus_unexpected: got we=%0b addr=%h data=%h, required no transfer",
                             mem_we, mem_addr, mem_wdata);
                end else begin
                    mon_e = bus_q.pop_front();
                    if (mem_we !== mon_e.we || mem_addr !== mon_e.a || (mon_e.we && mem_wdata !== mon_e.d)) begin
                        miscompares++;
                        $display("FAIL bus_xfer: got we=%0b addr=%h data=%h, required we=%0b addr=%h data=%h",
                                 mem_we, mem_addr, mem_wdata, mon_e.we, mon_e.a, mon_e.d);
                    end else begin
                        $display("xfer ok   we=%0b addr=%h data=%h", mem_we, mem_addr,
                                 mon_e.we ? mem_wdata : 32'h0);
                    end
                end
            end
            if (memread && !memwrite && !stall) begin
                vectors++;
                if (load_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL load_unexpected: got readdata=%h addr=%h, required no load", readdata, addr);
                end else begin
                    mon_ld = load_q.pop_front();
                    if (readdata !== mon_ld) begin
                        miscompares++;
                        $display("FAIL load_data: addr=%h got %h, required %h", addr, readdata, mon_ld);
                    end else begin
                        $display("load ok   addr=%h data=%h", addr, readdata);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end else begin
            $display("check ok  %s = %h", name, act);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic exp_bus(input bit we, input logic [31:0] a, input logic [31:0] d);
        bus_t e;
        e.we = we;
        e.a  = a;
        e.d  = d;
        bus_q.push_back(e);
    endtask

    // Present one CPU access and hold it until it retires; returns stalled cycles.
    task automatic cpu_op(input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] d, output int stalls);
        memwrite  = wr;
        memread   = rd;
        addr      = a;
        writedata = d;
        stalls    = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            stalls++;
            if (stalls > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL cpu_timeout: addr=%h still stalled after %0d cycles, required retire", a, stalls);
                break;
            end
        end
        @(posedge clk);
        #2;
        memwrite = 1'b0;
        memread  = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((bus_q.size() != 0 || mem_req) && t < 500) begin
            cycles(1);
            t++;
        end
        if (t >= 500) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d transfers outstanding, required 0", bus_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int n;

        // Reset state
        reset = 1'b0;
        cycles(3);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_readdata", readdata, 32'h0);
        reset = 1'b1;
        cycles(1);

        // Reset in the middle of a write
        ack_hold = 1'b1;
        cpu_op(1'b1, 1'b0, 32'h100, 32'hAAAA0001, st);
        chk("t1_store_stalls", 32'(st), 32'd0);
        cycles(2);
        chk("t1_req_pending", 32'(mem_req), 32'h1);
        chk("t1_we_pending", 32'(mem_we), 32'h1);
        reset = 1'b0;
        cycles(1);
        reset = 1'b1;
        chk("t1_req_after_rst", 32'(mem_req), 32'h0);
        chk("t1_stall_after_rst", 32'(stall), 32'h0);
        manual_ack = 1'b1;
        cycles(1);
        manual_ack = 1'b0;
        cycles(2);
        chk("t1_req_after_late_ack", 32'(mem_req), 32'h0);
        // Buffer was discarded, so this load must miss.
        ack_hold  = 1'b0;
        ack_delay = 1;
        rdata_val = 32'h5A5A0100;
        exp_bus(1'b0, 32'h100, 32'h0);
        load_q.push_back(32'h5A5A0100);
        cpu_op(1'b0, 1'b1, 32'h100, 32'h0, st);
        chk("t1_load_miss_stalls", 32'(st), 32'd2);
        wait_idle();

        // Posted stores, ack two cycles after each request
        ack_delay = 2;
        exp_bus(1'b1, 32'h10, 32'h10101010);
        exp_bus(1'b1, 32'h14, 32'h14141414);
        exp_bus(1'b1, 32'h18, 32'h18181818);
        cpu_op(1'b1, 1'b0, 32'h10, 32'h10101010, st);
        chk("t2_store0_stalls", 32'(st), 32'd0);
        cpu_op(1'b1, 1'b0, 32'h14, 32'h14141414, st);
        chk("t2_store1_stalls", 32'(st), 32'd0);
        cpu_op(1'b1, 1'b0, 32'h18, 32'h18181818, st);
        chk("t2_store2_stalls", 32'(st), 32'd0);
        wait_idle();
        chk("t2_drained_req", 32'(mem_req), 32'h0);

        // Forwarding from the youngest of two stores to the same word
        ack_hold = 1'b1;
        exp_bus(1'b1, 32'h20, 32'h11111111);
        exp_bus(1'b1, 32'h20, 32'h22222222);
        load_q.push_back(32'h22222222);
        cpu_op(1'b1, 1'b0, 32'h20, 32'h11111111, st);
        cpu_op(1'b1, 1'b0, 32'h20, 32'h22222222, st);
        cpu_op(1'b0, 1'b1, 32'h20, 32'h0, st);
        chk("t3_hit_stalls", 32'(st), 32'd0);
        ack_hold  = 1'b0;
        ack_delay = 1;
        wait_idle();

        // Load miss with single-cycle ack; low address bits are dropped
        ack_delay = 1;
        rdata_val = 32'hDEADBEEF;
        exp_bus(1'b0, 32'h40, 32'h0);
        load_q.push_back(32'hDEADBEEF);
        cpu_op(1'b0, 1'b1, 32'h43, 32'h0, st);
        chk("t4_miss_stalls", 32'(st), 32'd2);
        wait_idle();

        // Full buffer: fifth store stalls until a slot frees
        ack_hold = 1'b1;
        for (int i = 0; i < 5; i++) exp_bus(1'b1, 32'h300 + 32'(4 * i), 32'h50000000 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            cpu_op(1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'h50000000 + 32'(i), st);
            chk("t5_fill_stalls", 32'(st), 32'd0);
        end
        memwrite  = 1'b1;
        addr      = 32'h310;
        writedata = 32'h50000004;
        @(negedge clk);
        chk("t5_full_stall", 32'(stall), 32'h1);
        cycles(2);
        ack_hold = 1'b0;
        ack_delay = 1;
        n = 0;
        forever begin
            @(negedge clk);
            if (!stall || n > 50) break;
            n++;
        end
        chk("t5_release_stalls", 32'(n), 32'd2);
        @(posedge clk);
        #2;
        memwrite = 1'b0;
        wait_idle();

        // Load miss while a drain is in progress
        ack_hold  = 1'b1;
        ack_delay = 3;
        rdata_val = 32'hC0FFEE80;
        exp_bus(1'b1, 32'h200, 32'hA0A0A0A0);
        exp_bus(1'b0, 32'h80, 32'h0);
        exp_bus(1'b1, 32'h204, 32'hB0B0B0B0);
        load_q.push_back(32'hC0FFEE80);
        cpu_op(1'b1, 1'b0, 32'h200, 32'hA0A0A0A0, st);
        cpu_op(1'b1, 1'b0, 32'h204, 32'hB0B0B0B0, st);
        chk("t6_store_stalls", 32'(st), 32'd0);
        ack_hold = 1'b0;
        cpu_op(1'b0, 1'b1, 32'h80, 32'h0, st);
        wait_idle();

        cycles(3);
        chk("end_bus_queue", 32'(bus_q.size()), 32'd0);
        chk("end_load_queue", 32'(load_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_wbuf.md
Name: dmem_wbuf

Overview:
- Data-memory front end directly downstream of the single-cycle datapath. It consumes the ALU/result address, the store data and the memory-control strobes, and returns readdata.
- Stores are posted into a small write buffer and drained to a slow external memory over a req/ack handshake. Loads are forwarded from the buffer on an address hit; otherwise they are fetched from memory.
- Drives stall, which freezes the PC and register-file write for the cycle.

Parameters:
- DEPTH, 4, write-buffer entries; power of two, at least 2.
- AW, 32, address width in bits.
- DW, 32, data width in bits.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- memwrite  in  1  store this cycle.
- memread  in  1  load this cycle.
- addr  in  AW  byte address; bits [1:0] ignored (word access only).
- writedata  in  DW  store data.
- readdata  out  DW  load data; valid when memread=1 and stall=0.
- stall  out  1  CPU must hold the current instruction.
- mem_req  out  1  external request valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00}).
- mem_wdata  out  DW  write data.
- mem_ack  in  1  one-cycle completion pulse; ignored when mem_req=0.
- mem_rdata  in  DW  read data, valid with mem_ack on reads.

Behaviour:
- Reset (reset=0 at a clk edge):
  - Buffer emptied (count=0, pointers=0), FSM=IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, hold register=0.
  - stall=0; readdata=0.
  - Reset mid-transaction abandons the transaction. Buffered stores are discarded and any late mem_ack is ignored.
- Buffer: circular FIFO of {word address, data}, with count in 0..DEPTH.
  - Store with count<DEPTH: enqueue at the edge, no stall, zero-cycle cost.
  - Store with count==DEPTH: stall=1 until count<DEPTH. count is registered, so there is no same-cycle bypass from a pop. The enqueue occurs at the first edge where count<DEPTH.
- Load hit: memread=1 and any valid entry matches addr[AW-1:2].
  - readdata = data of the youngest matching entry, combinational, stall=0.
  - An entry being popped this cycle still counts as valid.
- Load miss: stall=1 and memory read performed through the FSM.
- memread and memwrite both 1: treated as a store; memread is ignored.
- Stores to an address already in the buffer are appended, not merged. Drain order equals program order.
- FSM states:
  - IDLE: mem_req=0.
    - Pending load miss goes to RD_BUSY; a load has priority over drain.
    - Otherwise, if count>0, go to WR_BUSY with the head entry.
    - Otherwise remain in IDLE.
  - WR_BUSY: mem_req=1, mem_we=1, address and data from the head entry, held stable until mem_ack.
    - On ack: pop the head (count-1; count unchanged if a simultaneous enqueue occurs).
    - Then go to RD_BUSY if a load miss is pending, else WR_BUSY with the new head if count after pop >0, else IDLE.
  - RD_BUSY: mem_req=1, mem_we=0, mem_addr from addr, held stable.
    - On ack: hold register <= mem_rdata, go to RD_DONE.
  - RD_DONE: stall=0, readdata=hold register. The CPU retires the load at this edge; next state IDLE.
  - Only a load in RD_DONE takes data from the hold register; hits and stores behave normally in every state.
- Load-miss latency: 1 cycle (IDLE→RD_BUSY) + memory latency + 1 cycle (RD_DONE). With single-cycle ack the load is stalled 2 cycles and retires in the 3rd.
- Outputs mem_* are registered. stall and readdata are combinational from registered state plus the current addr/memread/memwrite.
- Pointer wrap modulo DEPTH.
- Assertions:
  - mem_addr, mem_we and mem_wdata stable while mem_req=1 and mem_ack=0.
  - count never exceeds DEPTH and never underflows.

Decomposition:
- Shared package dmem_pkg: the FSM state enum (IDLE, WR_BUSY, RD_BUSY, RD_DONE) and a wbuf_entry_t struct {logic [AW-3:0] waddr; logic [DW-1:0] data;}.
- One sub-module, wbuf_fifo: storage, pointers, count, youngest-match search with a hit/hit_data output. The FSM and handshake stay in dmem_wbuf.

Test Plan:
- Reset mid-write: store 0x100=0xAAAA0001, hold mem_ack=0, reset=0 for 1 cycle → mem_req=0, count=0, stall=0; a later mem_ack pulse causes no pop and no state change.
- Posted stores plus drain: 3 stores to 0x10/0x14/0x18 with ack 2 cycles after each req → no stall, three writes in order with the correct data, count returns to 0.
- Forwarding: store 0x20=0x11111111, then 0x20=0x22222222, then load 0x20 (mem_ack=0) → readdata=0x22222222, stall=0, no read request.
- Load miss with single-cycle ack: empty buffer, load 0x40, mem_rdata=0xDEADBEEF → stall high 2 cycles, mem_we=0 req; readdata=0xDEADBEEF with stall=0 in the 3rd cycle.
- Full buffer: DEPTH+1 back-to-back stores, mem_ack held 0 → stall=1 on the 5th store; release ack → the 5th store is enqueued the edge after count<DEPTH, and all 5 drain in order.
- Load miss during drain: WR_BUSY active with 2 entries, issue load miss 0x80 → the read is issued after the current write acks and before the second buffered write.
